btn_filter: RTL and testbench

BTN_FILTER -- requirements
Module: btn_filter

---
 rtl/btn_filter.sv | 189 ++++++++++++++++++
 tb/tb_btn_filter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_filter.sv
// Multi-channel button debouncer: 2-flop synchroniser, shared tick prescaler and a
// per-channel debounce FSM producing a level plus press/release/long-hold pulses.
module btn_filter #(
  parameter int BT_WIDTH   = 8,
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BT_WIDTH-1:0] btn_in,
  output logic [BT_WIDTH-1:0] btn_level,
  output logic [BT_WIDTH-1:0] btn_press,
  output logic [BT_WIDTH-1:0] btn_release,
  output logic [BT_WIDTH-1:0] btn_long
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);
  localparam logic          REL_LVL   = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_REL     = 2'd0,
    ST_P_WAIT  = 2'd1,
    ST_PRESSED = 2'd2,
    ST_R_WAIT  = 2'd3
  } state_t;

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [BT_WIDTH-1:0] r_sync1;
  logic [BT_WIDTH-1:0] r_sync2;
  logic [BT_WIDTH-1:0] w_s;

  assign w_tick = (r_presc == PRESC_MAX);
  // Normalise polarity so that w_s = 1 always means "pressed".
  assign w_s    = r_sync2 ^ {BT_WIDTH{REL_LVL}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_sync1 <= {BT_WIDTH{REL_LVL}};
      r_sync2 <= {BT_WIDTH{REL_LVL}};
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BT_WIDTH; gi++) begin : g_ch
      state_t        r_state;
      state_t        w_state_next;
      logic [DW-1:0] r_deb;
      logic [DW-1:0] w_deb_next;
      logic [DW-1:0] w_deb_inc;
      logic [LW-1:0] r_long;
      logic [LW-1:0] w_long_next;
      logic [LW-1:0] w_long_inc;
      logic          r_fired;
      logic          w_fired_next;
      logic          r_level;
      logic          w_level_next;
      logic          r_press;
      logic          w_press_next;
      logic          r_release;
      logic          w_release_next;
      logic          r_long_pulse;
      logic          w_long_pulse_next;
      logic          w_rel_acc;

      assign w_deb_inc  = r_deb + DEB_ONE;
      assign w_long_inc = r_long + LONG_ONE;

      always_comb begin
        w_state_next      = r_state;
        w_deb_next        = r_deb;
        w_long_next       = r_long;
        w_fired_next      = r_fired;
        w_level_next      = r_level;
        w_press_next      = 1'b0;
        w_release_next    = 1'b0;
        w_long_pulse_next = 1'b0;
        w_rel_acc         = 1'b0;

        case (r_state)
          ST_REL: begin
            if (w_s[gi]) begin
              w_state_next = ST_P_WAIT;
              w_deb_next   = '0;
            end
          end
          ST_P_WAIT: begin
            if (!w_s[gi]) begin
              w_state_next = ST_REL;
              w_deb_next   = '0;
            end else if (w_tick) begin
              if (w_deb_inc == DEB_MAX) begin
                w_state_next = ST_PRESSED;
                w_deb_next   = '0;
                w_level_next = 1'b1;
                w_press_next = 1'b1;
              end else begin
                w_deb_next = w_deb_inc;
              end
            end
          end
          ST_PRESSED: begin
            if (!w_s[gi]) begin
              w_state_next = ST_R_WAIT;
              w_deb_next   = '0;
            end
          end
          ST_R_WAIT: begin
            if (w_s[gi]) begin
              w_state_next = ST_PRESSED;
              w_deb_next   = '0;
            end else if (w_tick) begin
              if (w_deb_inc == DEB_MAX) begin
                w_state_next   = ST_REL;
                w_deb_next     = '0;
                w_level_next   = 1'b0;
                w_release_next = 1'b1;
                w_long_next    = '0;
                w_fired_next   = 1'b0;
                w_rel_acc      = 1'b1;
              end else begin
                w_deb_next = w_deb_inc;
              end
            end
          end
          default: begin
            w_state_next = ST_REL;
            w_deb_next   = '0;
          end
        endcase

        // Hold timer runs through release bounces; an accepted release wins over the long pulse.
        if (w_tick && (r_state == ST_PRESSED || r_state == ST_R_WAIT) &&
            !w_rel_acc && (r_long != LONG_MAX)) begin
          w_long_next = w_long_inc;
          if ((w_long_inc == LONG_MAX) && !r_fired) begin
            w_long_pulse_next = 1'b1;
            w_fired_next      = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state      <= ST_REL;
          r_deb        <= '0;
          r_long       <= '0;
          r_fired      <= 1'b0;
          r_level      <= 1'b0;
          r_press      <= 1'b0;
          r_release    <= 1'b0;
          r_long_pulse <= 1'b0;
        end else begin
          r_state      <= w_state_next;
          r_deb        <= w_deb_next;
          r_long       <= w_long_next;
          r_fired      <= w_fired_next;
          r_level      <= w_level_next;
          r_press      <= w_press_next;
          r_release    <= w_release_next;
          r_long_pulse <= w_long_pulse_next;
        end
      end

      assign btn_level[gi]   = r_level;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;
      assign btn_long[gi]    = r_long_pulse;
    end
  endgenerate

endmodule

// File: tb/tb_btn_filter.sv
// Bench for btn_filter: directed scenarios plus random stimulus, every cycle compared
// against a behavioural model built on "accepted level vs. synchronised input" tick counting.
module tb_btn_filter;

  localparam int W  = 2;
  localparam int TD = 4;
  localparam int DEB = 3;
  localparam int LT = 6;
  localparam int AL = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn_in;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;
  logic [W-1:0] btn_long;

  btn_filter #(
    .BT_WIDTH  (W),
    .TICK_DIV  (TD),
    .DEB_TICKS (DEB),
    .LONG_TICKS(LT),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  int cyc = 0;

  // Reference model state
  logic [W-1:0] m_sync1 = '1;
  logic [W-1:0] m_sync2 = '1;
  logic [W-1:0] m_level = '0;
  logic [W-1:0] m_press = '0;
  logic [W-1:0] m_release = '0;
  logic [W-1:0] m_long = '0;
  logic [W-1:0] m_prev = '0;   // input already differed from accepted level last cycle
  int m_cnt[W];
  int m_held[W];
  int m_cyc = 0;

  // Observation counters
  int c_press[W];
  int c_release[W];
  int c_long[W];
  int c_lvl_hi0;
  int c_ch1;
  int t_press0;
  int t_long0;
  logic [W-1:0] first_press;
  logic [W-1:0] first_rel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock of the reference: same inputs the DUT sampled at the last rising edge.
  task automatic model_step();
    logic tick;
    logic s;
    logic lvl_old;
    logic rel;
    if (rst) begin
      m_sync1   = (AL != 0) ? '1 : '0;
      m_sync2   = (AL != 0) ? '1 : '0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_long    = '0;
      m_prev    = '0;
      m_cyc     = 0;
      for (int i = 0; i < W; i++) begin
        m_cnt[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      tick = ((m_cyc % TD) == TD - 1);
      for (int i = 0; i < W; i++) begin
        s       = m_sync2[i] ^ (AL != 0);
        lvl_old = m_level[i];
        rel     = 1'b0;
        m_press[i]   = 1'b0;
        m_release[i] = 1'b0;
        m_long[i]    = 1'b0;
        if (s == m_level[i]) begin
          m_cnt[i] = 0;
        end else if (m_prev[i] && tick) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_cnt[i]   = 0;
            m_level[i] = s;
            if (s) begin
              m_press[i] = 1'b1;
            end else begin
              m_release[i] = 1'b1;
              m_held[i]    = 0;
              rel          = 1'b1;
            end
          end
        end
        m_prev[i] = (s != m_level[i]);
        if (tick && lvl_old && !rel && m_held[i] < LT) begin
          m_held[i]++;
          if (m_held[i] == LT) m_long[i] = 1'b1;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = btn_in;
      m_cyc++;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      c_press[i]   = 0;
      c_release[i] = 0;
      c_long[i]    = 0;
    end
    c_lvl_hi0   = 0;
    c_ch1       = 0;
    t_press0    = -1;
    t_long0     = -1;
    first_press = '0;
    first_rel   = '0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      model_step();
      cyc++;
      if (chk_en) begin
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_release));
        check("long",    32'(btn_long),    32'(m_long));
      end
      for (int i = 0; i < W; i++) begin
        if (btn_press[i])   c_press[i]++;
        if (btn_release[i]) c_release[i]++;
        if (btn_long[i])    c_long[i]++;
      end
      if (btn_press[0]) t_press0 = cyc;
      if (btn_long[0])  t_long0  = cyc;
      if (btn_level[0]) c_lvl_hi0++;
      if (btn_level[1] | btn_press[1] | btn_release[1] | btn_long[1]) c_ch1++;
      if (btn_press != '0 && first_press == '0)  first_press = btn_press;
      if (btn_release != '0 && first_rel == '0)  first_rel   = btn_release;
      if (|{btn_press, btn_release, btn_long})
        $display("cyc %0d press=%b release=%b long=%b level=%b",
                 cyc, btn_press, btn_release, btn_long, btn_level);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hold[W];
    bit found;

    btn_in = 2'b11;
    rst    = 1'b1;
    clear_counts();
    step(3);
    chk_en = 1'b1;
    step(1);
    check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
    rst = 1'b0;
    step(4);
    $display("scenario reset done");

    // Clean press on channel 0, channel 1 idle
    clear_counts();
    btn_in = 2'b10;
    lat = 0;
    while (c_press[0] == 0 && lat < 16) begin
      step(1);
      lat++;
    end
    check("clean_press_within_bound", 32'(c_press[0]), 32'd1);
    step(4);
    check("clean_press_once", 32'(c_press[0]), 32'd1);
    check("clean_level_high", 32'(btn_level[0]), 32'd1);
    check("clean_ch1_quiet", 32'(c_ch1), 32'd0);
    btn_in = 2'b11;
    step(30);
    check("clean_release_once", 32'(c_release[0]), 32'd1);
    check("clean_level_low", 32'(btn_level[0]), 32'd0);
    $display("scenario clean press done");

    // Bounce: toggle every 3 cycles, then settle pressed
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      btn_in = {1'b1, (k % 2) == 1};
      step(3);
    end
    check("bounce_no_press", 32'(c_press[0]), 32'd0);
    check("bounce_no_level", 32'(c_lvl_hi0), 32'd0);
    btn_in = 2'b10;
    step(20);
    check("bounce_settle_press", 32'(c_press[0]), 32'd1);
    btn_in = 2'b11;
    step(30);
    check("bounce_release", 32'(c_release[0]), 32'd1);
    $display("scenario bounce done");

    // Long press: one long pulse LT ticks after the accepting tick
    clear_counts();
    btn_in = 2'b10;
    step(60);
    check("long_press_once", 32'(c_press[0]), 32'd1);
    check("long_pulse_once", 32'(c_long[0]), 32'd1);
    check("long_gap_cycles", 32'(t_long0 - t_press0), 32'(LT * TD));
    btn_in = 2'b11;
    step(30);
    check("long_release_once", 32'(c_release[0]), 32'd1);
    check("long_no_repeat", 32'(c_long[0]), 32'd1);
    check("long_level_low", 32'(btn_level[0]), 32'd0);
    $display("scenario long press done");

    // Short release glitch while pressed
    clear_counts();
    btn_in = 2'b10;
    step(20);
    check("glitch_press", 32'(c_press[0]), 32'd1);
    btn_in = 2'b11;
    step(5);
    btn_in = 2'b10;
    step(20);
    check("glitch_no_release", 32'(c_release[0]), 32'd0);
    check("glitch_level_high", 32'(btn_level[0]), 32'd1);
    check("glitch_long_continues", 32'(c_long[0]), 32'd1);
    btn_in = 2'b11;
    step(30);
    $display("scenario release glitch done");

    // Reset while channel 0 is two ticks into press qualification
    clear_counts();
    btn_in = 2'b10;
    found = 1'b0;
    lat = 0;
    while (!found && lat < 20) begin
      step(1);
      lat++;
      if (m_cnt[0] == 2) found = 1'b1;
    end
    check("reach_pwait_cnt2", 32'(found), 32'd1);
    rst = 1'b1;
    step(1);
    check("rst_mid_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'h0);
    check("rst_mid_no_pulse", 32'(c_press[0] + c_release[0] + c_long[0]), 32'd0);
    rst = 1'b0;
    lat = 0;
    while (c_press[0] == 0 && lat < 30) begin
      step(1);
      lat++;
    end
    // 2 sync edges + 1 edge to enter the wait state, then ticks at 4, 8, 12 after reset
    check("requal_latency", 32'(lat), 32'd12);
    btn_in = 2'b11;
    step(30);
    $display("scenario reset mid-press done");

    // Both channels together
    clear_counts();
    btn_in = 2'b00;
    lat = 0;
    while (first_press == '0 && lat < 20) begin
      step(1);
      lat++;
    end
    check("sim_press", 32'(first_press), 32'h3);
    step(5);
    btn_in = 2'b11;
    lat = 0;
    while (first_rel == '0 && lat < 20) begin
      step(1);
      lat++;
    end
    check("sim_release", 32'(first_rel), 32'h3);
    step(10);
    $display("scenario simultaneous done");

    // Random hold lengths per channel with rare resets
    clear_counts();
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          hold[i]   = $urandom_range(1, 50);
        end else begin
          hold[i]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    btn_in = 2'b11;
    step(40);
    $display("scenario random done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
